// File: rtl/pwm_mixer_n.sv
// pwm_mixer_n: CHANNELS independent quadrature-encoder channels. Each channel
// debounces its raw A/B pins, decodes quadrature steps into a WIDTH-bit level
// (saturating or wrapping), and drives a glitch-free PWM. A host can preset any
// level, and a registered readout mux exposes one channel at a time.
//
// Ports:
//   clk, reset          - system clock, asynchronous active-high reset
//   enc_a, enc_b        - raw encoder inputs, bit i = channel i
//   enc_sel             - readout channel select
//   load_valid          - preset write strobe
//   load_chan           - preset target channel
//   load_value          - preset level
//   enc_val             - registered level of the selected channel
//   debounce_a/_b       - registered debounced A/B of the selected channel
//   pwm_out             - registered PWM outputs, bit i = channel i
//
// Handshake: load_valid is a single-cycle strobe with no ready. The core always
// accepts; a write takes effect on the edge where load_valid is sampled high,
// and is dropped silently when load_chan does not name an existing channel.
module pwm_mixer_n #(
  parameter int CHANNELS = 3,
  parameter int WIDTH    = 8,
  parameter int HIST_LEN = 8,
  parameter int SATURATE = 1,
  parameter int SEL_W    = $clog2(CHANNELS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] enc_a,
  input  logic [CHANNELS-1:0] enc_b,
  input  logic [SEL_W-1:0]    enc_sel,
  input  logic                load_valid,
  input  logic [SEL_W-1:0]    load_chan,
  input  logic [WIDTH-1:0]    load_value,
  output logic [WIDTH-1:0]    enc_val,
  output logic                debounce_a,
  output logic                debounce_b,
  output logic [CHANNELS-1:0] pwm_out
);

  localparam logic [WIDTH-1:0] LVL_MAX = '1;

  logic [CHANNELS-1:0][HIST_LEN-1:0] hist_a_q, hist_a_d, hist_b_q, hist_b_d;
  logic [CHANNELS-1:0]               deb_a_q, deb_a_d, deb_b_q, deb_b_d;
  logic [CHANNELS-1:0][1:0]          prev_ab_q, prev_ab_d;
  logic [CHANNELS-1:0]               step_inc, step_dec;
  logic [CHANNELS-1:0][WIDTH-1:0]    level_q, level_d, active_q, active_d;
  logic [WIDTH-1:0]                  cnt_q, cnt_d;
  logic [CHANNELS-1:0]               pwm_q, pwm_d;
  logic [WIDTH-1:0]                  enc_val_q, enc_val_d;
  logic                              dbg_a_q, dbg_a_d, dbg_b_q, dbg_b_d;

  // Per-channel datapath: debounce, decode, level update, PWM compare.
  always_comb begin
    hist_a_d  = hist_a_q;
    hist_b_d  = hist_b_q;
    deb_a_d   = deb_a_q;
    deb_b_d   = deb_b_q;
    prev_ab_d = prev_ab_q;
    step_inc  = '0;
    step_dec  = '0;
    level_d   = level_q;
    active_d  = active_q;
    pwm_d     = '0;
    cnt_d     = cnt_q + WIDTH'(1);
    for (int i = 0; i < CHANNELS; i++) begin
      hist_a_d[i] = {hist_a_q[i][HIST_LEN-2:0], enc_a[i]};
      hist_b_d[i] = {hist_b_q[i][HIST_LEN-2:0], enc_b[i]};
      // Debounced bit follows only a unanimous history; mixed history holds.
      if (&hist_a_q[i])       deb_a_d[i] = 1'b1;
      else if (~|hist_a_q[i]) deb_a_d[i] = 1'b0;
      if (&hist_b_q[i])       deb_b_d[i] = 1'b1;
      else if (~|hist_b_q[i]) deb_b_d[i] = 1'b0;

      prev_ab_d[i] = {deb_a_q[i], deb_b_q[i]};
      // Only the two single-bit transitions out of 00 and 11 count; every
      // other change (including double-bit jumps) is ignored.
      step_inc[i] = (prev_ab_q[i] == 2'b00 && {deb_a_q[i], deb_b_q[i]} == 2'b10) ||
                    (prev_ab_q[i] == 2'b11 && {deb_a_q[i], deb_b_q[i]} == 2'b01);
      step_dec[i] = (prev_ab_q[i] == 2'b00 && {deb_a_q[i], deb_b_q[i]} == 2'b01) ||
                    (prev_ab_q[i] == 2'b11 && {deb_a_q[i], deb_b_q[i]} == 2'b10);

      if (step_inc[i]) begin
        if (!(SATURATE != 0 && level_q[i] == LVL_MAX)) level_d[i] = level_q[i] + WIDTH'(1);
      end else if (step_dec[i]) begin
        if (!(SATURATE != 0 && level_q[i] == '0)) level_d[i] = level_q[i] - WIDTH'(1);
      end
      // A preset overrides a coincident step on the same channel.
      if (load_valid && int'(load_chan) == i) level_d[i] = load_value;

      // Duty is sampled only at the period boundary; the compare uses the
      // value being latched so the whole period sees one duty.
      if (cnt_q == '0) active_d[i] = level_q[i];
      pwm_d[i] = (cnt_q < active_d[i]);
    end
  end

  // Readout mux: out-of-range selects read as zero.
  always_comb begin
    enc_val_d = '0;
    dbg_a_d   = 1'b0;
    dbg_b_d   = 1'b0;
    if (int'(enc_sel) < CHANNELS) begin
      enc_val_d = level_q[enc_sel];
      dbg_a_d   = deb_a_q[enc_sel];
      dbg_b_d   = deb_b_q[enc_sel];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hist_a_q  <= '0;
      hist_b_q  <= '0;
      deb_a_q   <= '0;
      deb_b_q   <= '0;
      prev_ab_q <= '0;
      level_q   <= '0;
      active_q  <= '0;
      cnt_q     <= '0;
      pwm_q     <= '0;
      enc_val_q <= '0;
      dbg_a_q   <= 1'b0;
      dbg_b_q   <= 1'b0;
    end else begin
      hist_a_q  <= hist_a_d;
      hist_b_q  <= hist_b_d;
      deb_a_q   <= deb_a_d;
      deb_b_q   <= deb_b_d;
      prev_ab_q <= prev_ab_d;
      level_q   <= level_d;
      active_q  <= active_d;
      cnt_q     <= cnt_d;
      pwm_q     <= pwm_d;
      enc_val_q <= enc_val_d;
      dbg_a_q   <= dbg_a_d;
      dbg_b_q   <= dbg_b_d;
    end
  end

  assign enc_val    = enc_val_q;
  assign debounce_a = dbg_a_q;
  assign debounce_b = dbg_b_q;
  assign pwm_out    = pwm_q;

endmodule
